// File: rtl/dhcp_pkg.sv
// rtl/dhcp_pkg.sv - shared BOOTP/DHCP frame constants for the DHCP transmitter and receiver
package dhcp_pkg;

  localparam logic [7:0] OP_BOOTREQUEST = 8'd1;
  localparam logic [7:0] HTYPE_ETH      = 8'd1;
  localparam logic [7:0] HLEN_ETH       = 8'd6;
  localparam logic [15:0] FLAGS_BROADCAST = 16'h0080;

  // Magic cookie 99.130.83.99 in wire order
  localparam logic [7:0] COOKIE_0 = 8'h63;
  localparam logic [7:0] COOKIE_1 = 8'h82;
  localparam logic [7:0] COOKIE_2 = 8'h53;
  localparam logic [7:0] COOKIE_3 = 8'h63;

  localparam logic [7:0] OPT_REQ_IP    = 8'd50;
  localparam logic [7:0] OPT_MSG_TYPE  = 8'd53;
  localparam logic [7:0] OPT_SERVER_ID = 8'd54;
  localparam logic [7:0] OPT_END       = 8'd255;

  localparam logic [7:0] DHCPDISCOVER = 8'd1;
  localparam logic [7:0] DHCPOFFER    = 8'd2;
  localparam logic [7:0] DHCPREQUEST  = 8'd3;
  localparam logic [7:0] DHCPACK      = 8'd5;

  localparam int LEN_DISCOVER = 122;
  localparam int LEN_REQUEST  = 128;

  localparam logic [6:0] W_OP      = 7'd0;
  localparam logic [6:0] W_HLEN    = 7'd1;
  localparam logic [6:0] W_XID     = 7'd2;
  localparam logic [6:0] W_SECS    = 7'd4;
  localparam logic [6:0] W_FLAGS   = 7'd5;
  localparam logic [6:0] W_CHADDR  = 7'd14;
  localparam logic [6:0] W_COOKIE  = 7'd118;
  localparam logic [6:0] W_OPTIONS = 7'd120;

  typedef enum logic {
    KIND_DISCOVER = 1'b0,
    KIND_REQUEST  = 1'b1
  } msg_kind_t;

  function automatic logic [6:0] last_word(input msg_kind_t kind);
    last_word = (kind == KIND_REQUEST) ? 7'(LEN_REQUEST - 1) : 7'(LEN_DISCOVER - 1);
  endfunction

endpackage

// File: rtl/dhcptx_wordmux.sv
// rtl/dhcptx_wordmux.sv - combinational payload word selection by word index and message kind
import dhcp_pkg::*;

module dhcptx_wordmux (
  input  logic [6:0]  index,
  input  msg_kind_t   kind,
  input  logic [31:0] xid,
  input  logic [47:0] chaddr,
  input  logic [31:0] reqipaddr,
  input  logic [31:0] serverid,
  output logic [15:0] word
);

  logic req;
  assign req = (kind == KIND_REQUEST);

  // Low byte of each word is the earlier byte on the wire
  always_comb begin
    word = 16'h0000;
    case (index)
      W_OP:              word = {HTYPE_ETH, OP_BOOTREQUEST};
      W_HLEN:            word = {8'h00, HLEN_ETH};
      W_XID:             word = xid[15:0];
      W_XID + 7'd1:      word = xid[31:16];
      W_FLAGS:           word = FLAGS_BROADCAST;
      W_CHADDR:          word = chaddr[15:0];
      W_CHADDR + 7'd1:   word = chaddr[31:16];
      W_CHADDR + 7'd2:   word = chaddr[47:32];
      W_COOKIE:          word = {COOKIE_1, COOKIE_0};
      W_COOKIE + 7'd1:   word = {COOKIE_3, COOKIE_2};
      W_OPTIONS:         word = {8'd1, OPT_MSG_TYPE};
      W_OPTIONS + 7'd1:  word = req ? {OPT_REQ_IP, DHCPREQUEST} : {OPT_END, DHCPDISCOVER};
      W_OPTIONS + 7'd2:  word = req ? {reqipaddr[7:0], 8'd4} : 16'h0000;
      W_OPTIONS + 7'd3:  word = req ? reqipaddr[23:8] : 16'h0000;
      W_OPTIONS + 7'd4:  word = req ? {OPT_SERVER_ID, reqipaddr[31:24]} : 16'h0000;
      W_OPTIONS + 7'd5:  word = req ? {serverid[7:0], 8'd4} : 16'h0000;
      W_OPTIONS + 7'd6:  word = req ? serverid[23:8] : 16'h0000;
      W_OPTIONS + 7'd7:  word = req ? {OPT_END, serverid[31:24]} : 16'h0000;
      default:           word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dhcptx.sv
// rtl/dhcptx.sv - DHCP client transmitter streaming DISCOVER/REQUEST payload words
import dhcp_pkg::*;

module dhcptx (
  input  logic        clock,
  input  logic        reset,
  input  logic        senddiscover,
  input  logic        sendrequest,
  input  logic [31:0] xid,
  input  logic [47:0] chaddr,
  input  logic [31:0] reqipaddr,
  input  logic [31:0] serverid,
  input  logic        ready,
  output logic        validout,
  output logic        sof,
  output logic        eof,
  output logic [15:0] dataout,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [6:0]  idx;
  msg_kind_t   kind;
  logic [31:0] xid_q;
  logic [47:0] chaddr_q;
  logic [31:0] reqip_q;
  logic [31:0] serverid_q;
  logic [6:0]  sel_idx;
  logic [6:0]  last_idx;
  logic [15:0] word;

  // idx names the word held in the output register; the mux looks one word ahead once loaded
  assign sel_idx  = validout ? idx + 7'd1 : idx;
  assign last_idx = last_word(kind);
  assign busy     = (state == ST_SEND);

  dhcptx_wordmux u_wordmux (
    .index     (sel_idx),
    .kind      (kind),
    .xid       (xid_q),
    .chaddr    (chaddr_q),
    .reqipaddr (reqip_q),
    .serverid  (serverid_q),
    .word      (word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= 7'd0;
      kind       <= KIND_DISCOVER;
      xid_q      <= 32'h0;
      chaddr_q   <= 48'h0;
      reqip_q    <= 32'h0;
      serverid_q <= 32'h0;
      validout   <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      dataout    <= 16'h0000;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (senddiscover || sendrequest) begin
            kind       <= senddiscover ? KIND_DISCOVER : KIND_REQUEST;
            xid_q      <= xid;
            chaddr_q   <= chaddr;
            reqip_q    <= reqipaddr;
            serverid_q <= serverid;
            idx        <= 7'd0;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!validout) begin
            validout <= 1'b1;
            dataout  <= word;
            sof      <= (sel_idx == 7'd0);
            eof      <= (sel_idx == last_idx);
          end else if (ready) begin
            if (eof) begin
              validout <= 1'b0;
              sof      <= 1'b0;
              eof      <= 1'b0;
              dataout  <= 16'h0000;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              idx     <= sel_idx;
              dataout <= word;
              sof     <= 1'b0;
              eof     <= (sel_idx == last_idx);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dhcptx.md
# dhcptx

DHCP client transmitter: builds a complete BOOTP/DHCP payload (DHCPDISCOVER or DHCPREQUEST) and streams it as 16-bit words with sof/eof framing to the UDP/IP encapsulation layer. It is the transmit counterpart of the DHCP receive parser. Word and byte ordering match the receiver: multi-word fields go low half first, and `dataout[7:0]` is the earlier byte on the wire. The client FSM supplies xid, MAC and, for requests, the offered IP and server id taken from the received OFFER.

## Interface
- No parameters; all frame constants come from the shared package.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `senddiscover` in 1: start-DISCOVER strobe, sampled in IDLE.
- `sendrequest` in 1: start-REQUEST strobe, sampled in IDLE.
- `xid` in 32: transaction id.
- `chaddr` in 48: client MAC; byte 0 is `chaddr[7:0]`.
- `reqipaddr` in 32: option 50 value (REQUEST only).
- `serverid` in 32: option 54 value (REQUEST only).
- `ready` in 1: downstream accepts the current word.
- `validout` out 1: `dataout` holds a valid word.
- `sof` out 1: first word of the frame (qualified by validout).
- `eof` out 1: last word of the frame (qualified by validout).
- `dataout` out 16: payload word.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, SEND, DONE.
- IDLE:
  - `senddiscover` or `sendrequest` high → latch all inputs and the message kind, clear the word index, go to SEND.
  - If both strobes are high in the same cycle, DISCOVER wins.
- SEND:
  - `validout`=1, `busy`=1.
  - A transfer happens only when `validout && ready`; the index then increments.
  - While `ready`=0, `dataout`, `sof` and `eof` hold steady.
  - Transfer of the last word → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE.
- Start strobes in SEND or DONE are ignored; they are not queued.
- Word map, index 0..127, 7-bit counter:
  - 0 = 0x0101 (op=1, htype=1); 1 = 0x0006 (hlen=6, hops=0).
  - 2–3 = xid[15:0], xid[31:16]; 4 = 0x0000 (secs); 5 = 0x0080 (broadcast flag).
  - 6–13 = 0 (ciaddr, yiaddr, siaddr, giaddr).
  - 14–16 = chaddr[15:0], [31:16], [47:32]; 17–21 = 0.
  - 22–117 = 0 (sname, file); 118 = 0x8263, 119 = 0x6353 (magic cookie).
- DISCOVER options:
  - 120 = 0x0135 (option 53, length 1).
  - 121 = 0xFF01 (type 1, end).
  - Length 122 words; eof on 121.
- REQUEST options:
  - 120 = 0x0135; 121 = 0x3203; 122 = {reqipaddr[7:0],0x04}; 123 = reqipaddr[23:8].
  - 124 = {0x36,reqipaddr[31:24]}; 125 = {serverid[7:0],0x04}; 126 = serverid[23:8]; 127 = {0xFF,serverid[31:24]}.
  - Length 128 words; eof on 127.
- Inputs changing mid-frame do not affect the frame, because the values are latched at start.

## Timing
- Reset values: `validout`, `sof`, `eof`, `busy`, `done` = 0; `dataout` = 0x0000; state IDLE; index 0.
- Reset mid-frame aborts the frame within one cycle with no eof; the next start is clean.
- Latency: strobe sampled at edge N → word 0 with `validout`=1 and `sof`=1 after edge N+1.
- With `ready` held at 1, one word per cycle: DISCOVER occupies 122 cycles, REQUEST 128.
- `done` asserts the cycle after the eof transfer. The earliest new start is sampled the cycle after `done`.
- `sof` and `eof` are never high together.
- `dataout` is registered and driven 0 when `validout`=0.

## Structure
- Shared package `dhcp_pkg` holds:
  - op/htype/hlen constants, cookie words;
  - option codes 50/53/54/255 and message types DISCOVER=1, REQUEST=3 (OFFER=2, ACK=5 for the receiver);
  - frame lengths 122/128 and field word offsets.
- Sub-module `dhcptx_wordmux` (combinational): takes the index, kind and latched fields and returns the word. The top level holds the FSM, counter, latches and output registers.

## Test plan
- DISCOVER, xid=0x12345678, chaddr=0x0A0B0C0D0E0F, `ready`=1:
  - 122 consecutive words; w2=0x5678, w3=0x1234, w14=0x0E0F, w16=0x0A0B;
  - w118/119=0x8263/0x6353, w121=0xFF01 with eof; `done` one cycle later.
- REQUEST, reqipaddr=0xC0A80164, serverid=0xC0A80101:
  - w122=0x6404, w123=0xA801, w124=0x36C0, w125=0x0104, w126=0xA801, w127=0xFFC0;
  - eof only on w127.
- Random `ready` backpressure: word sequence identical to the no-stall run; `dataout` stable through every stall.
- `senddiscover` and `sendrequest` strobed together → DISCOVER frame. A strobe pulsed mid-frame → ignored, no second frame.
- `reset` at word 50 → all outputs 0 next cycle. A following DISCOVER starts at w0 with sof.
- xid changed mid-frame after w2 → w3 still carries the latched xid[31:16].
